// File: rtl/exe_pkg.sv
// Shared decode constants, FSM state type and operand-select helpers for the execute stage.
package exe_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_SLT  = 6'b000100;
  localparam logic [5:0] OP_MUL  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b001001;
  localparam logic [5:0] OP_ADDI = 6'b010000;
  localparam logic [5:0] OP_SUBI = 6'b010001;
  localparam logic [5:0] OP_SLTI = 6'b010100;
  localparam logic [5:0] OP_BEQZ = 6'b110100;
  localparam logic [5:0] OP_BNEZ = 6'b110101;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } exe_state_t;

  // Branches take the next PC as operand A.
  function automatic logic sel_a_npc(input logic [5:0] opcode);
    return opcode[5:2] == 4'b1101;
  endfunction

  // Immediate forms and memory ops take the immediate as operand B.
  function automatic logic sel_b_imm(input logic [5:0] opcode);
    return opcode[4] || (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low XLEN bits of the unsigned product.
module exe_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clear,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   count;
  logic            run;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign busy     = run;
  // done fires during the final step so the caller can capture the product on the same edge.
  assign done     = run && (count == CW'(1));
  assign product  = (count != '0) ? acc_next : acc;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (clear) begin
      run   <= 1'b0;
      count <= '0;
      acc   <= '0;
    end else if (start) begin
      run    <= 1'b1;
      count  <= CW'(XLEN);
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (count != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Registered MIPS32-style execute stage with valid/ready on both sides.
// Define EXE_MULDIV_EN to build the iterative MUL path; otherwise MUL decodes as illegal.
module exe_stage
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] npc_in,
  input  logic [31:0]     ir_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] b_ex,
  output logic [XLEN-1:0] npc_ex,
  output logic [31:0]     ir_ex,
  output logic            cond_ex,
  output logic            illegal_ex
);

  logic [5:0]      opcode;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] res;
  logic            cond;
  logic            illegal;
  logic            alive;
  logic            free;
  logic            accept;
  logic            load_in;

  assign opcode = ir_in[31:26];
  assign free   = !out_valid || out_ready;
  assign accept = in_valid && in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    op_a    = sel_a_npc(opcode) ? npc_in : a_in;
    op_b    = sel_b_imm(opcode) ? imm_in : b_in;
    res     = '0;
    cond    = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: res = op_a + op_b;
      OP_SUB, OP_SUBI:               res = op_a - op_b;
      OP_AND:                        res = op_a & op_b;
      OP_OR:                         res = op_a | op_b;
      OP_SLT, OP_SLTI:               res = XLEN'($signed(op_a) < $signed(op_b));
      OP_BEQZ: begin
        res  = op_a + op_b;
        cond = (a_in == '0);
      end
      OP_BNEZ: begin
        res  = op_a + op_b;
        cond = (a_in != '0);
      end
      OP_HLT:                        res = '0;
`ifdef EXE_MULDIV_EN
      OP_MUL:                        res = '0;
`endif
      default:                       illegal = 1'b1;
    endcase
  end

`ifdef EXE_MULDIV_EN
  exe_state_t      state;
  logic            is_mul;
  logic            mul_start;
  logic            mul_clear;
  logic            mul_load;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;
  logic [XLEN-1:0] mul_b;
  logic [XLEN-1:0] mul_npc;
  logic [31:0]     mul_ir;

  assign is_mul    = (opcode == OP_MUL);
  assign in_ready  = alive && (state == IDLE) && !mul_busy && !flush && free;
  assign load_in   = accept && !is_mul;
  assign mul_start = accept && is_mul;
  assign mul_load  = !flush && free && ((state == RUN && mul_done) || state == HOLD);
  assign mul_clear = flush || mul_load;

  exe_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .clear   (mul_clear),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign in_ready = alive && !flush && free;
  assign load_in  = accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive      <= 1'b0;
      out_valid  <= 1'b0;
      alu_out    <= '0;
      b_ex       <= '0;
      npc_ex     <= '0;
      ir_ex      <= '0;
      cond_ex    <= 1'b0;
      illegal_ex <= 1'b0;
`ifdef EXE_MULDIV_EN
      state      <= IDLE;
      mul_b      <= '0;
      mul_npc    <= '0;
      mul_ir     <= '0;
`endif
    end else begin
      alive <= 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load_in) begin
        out_valid  <= 1'b1;
        alu_out    <= res;
        b_ex       <= b_in;
        npc_ex     <= cond ? res : npc_in;
        ir_ex      <= ir_in;
        cond_ex    <= cond;
        illegal_ex <= illegal;
      end
`ifdef EXE_MULDIV_EN
      else if (mul_load) begin
        out_valid  <= 1'b1;
        alu_out    <= mul_prod;
        b_ex       <= mul_b;
        npc_ex     <= mul_npc;
        ir_ex      <= mul_ir;
        cond_ex    <= 1'b0;
        illegal_ex <= 1'b0;
      end
`endif
      else if (out_ready) begin
        out_valid <= 1'b0;
      end

`ifdef EXE_MULDIV_EN
      // Side fields of a MUL are captured at acceptance and replayed when the product lands.
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (mul_start) begin
            state   <= RUN;
            mul_b   <= b_in;
            mul_npc <= npc_in;
            mul_ir  <= ir_in;
          end
          RUN:     if (mul_done) state <= free ? IDLE : HOLD;
          HOLD:    if (free) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
`endif
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vectors, a per-op model and an in-order scoreboard.
module tb_exe_stage;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in, b_in, imm_in, npc_in, ir_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out, b_ex, npc_ex, ir_ex;
  logic        cond_ex;
  logic        illegal_ex;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] b;
    logic [31:0] npc;
    logic [31:0] ir;
    logic        cond;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];

  exe_stage #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .imm_in     (imm_in),
    .npc_in     (npc_in),
    .ir_in      (ir_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_out    (alu_out),
    .b_ex       (b_ex),
    .npc_ex     (npc_ex),
    .ir_ex      (ir_ex),
    .cond_ex    (cond_ex),
    .illegal_ex (illegal_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // What the stage must produce for one instruction, straight from the opcode table.
  function automatic exp_t model(input logic [31:0] a, b, imm, npc, ir);
    exp_t e;
    logic [5:0] op;
    op     = ir[31:26];
    e.alu  = 32'h0;
    e.b    = b;
    e.npc  = npc;
    e.ir   = ir;
    e.cond = 1'b0;
    e.ill  = 1'b0;
    case (op)
      6'b000000: e.alu = a + b;
      6'b000001: e.alu = a - b;
      6'b000010: e.alu = a & b;
      6'b000011: e.alu = a | b;
      6'b000100: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b000101: begin
`ifdef EXE_MULDIV_EN
        e.alu = a * b;
`else
        e.ill = 1'b1;
`endif
      end
      6'b001000, 6'b001001: e.alu = a + imm;
      6'b010000: e.alu = a + imm;
      6'b010001: e.alu = a - imm;
      6'b010100: e.alu = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      6'b110100, 6'b110101: begin
        e.alu  = npc + imm;
        e.cond = (op[0] == 1'b0) ? (a == 32'h0) : (a != 32'h0);
        if (e.cond) e.npc = e.alu;
      end
      6'b111111: e.alu = 32'h0;
      default:   e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Offer one instruction and wait (bounded) for the handshake; waits = cycles until accepted.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, b, imm, npc, output int waits);
    bit done;
    done     = 1'b0;
    waits    = 0;
    ir_in    = {op, 26'h15A5A5A};
    a_in     = a;
    b_in     = b;
    imm_in   = imm;
    npc_in   = npc;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      waits++;
      if (in_ready) begin
        exp_q.push_back(model(a, b, imm, npc, {op, 26'h15A5A5A}));
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Single-cycle op with literal expectations checked on the cycle after acceptance.
  task automatic alu_case(input string name, input logic [5:0] op, input logic [31:0] a, b, imm, npc,
                          input logic [31:0] e_alu, input logic e_cond, input logic [31:0] e_npc,
                          input logic e_ill);
    int w;
    issue(op, a, b, imm, npc, w);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_alu"}, alu_out, e_alu);
    check({name, "_cond"}, {31'd0, cond_ex}, {31'd0, e_cond});
    check({name, "_npc"}, npc_ex, e_npc);
    check({name, "_ill"}, {31'd0, illegal_ex}, {31'd0, e_ill});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consumed result must match the oldest pending model entry, and a
  // stalled result must not move.
  initial begin : compare
    exp_t        e;
    bit          held;
    logic [31:0] h_alu, h_npc, h_ir;
    logic        h_cond, h_ill;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", {31'd0, out_valid}, 32'd1);
          check("hold_alu", alu_out, h_alu);
          check("hold_npc", npc_ex, h_npc);
          check("hold_ir", ir_ex, h_ir);
          check("hold_flags", {30'd0, cond_ex, illegal_ex}, {30'd0, h_cond, h_ill});
        end
        if (out_valid && out_ready && !flush) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", {31'd0, out_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("sb_alu", alu_out, e.alu);
            check("sb_b", b_ex, e.b);
            check("sb_npc", npc_ex, e.npc);
            check("sb_ir", ir_ex, e.ir);
            check("sb_cond", {31'd0, cond_ex}, {31'd0, e.cond});
            check("sb_ill", {31'd0, illegal_ex}, {31'd0, e.ill});
          end
        end
        held   = out_valid && !out_ready && !flush;
        h_alu  = alu_out;
        h_npc  = npc_ex;
        h_ir   = ir_ex;
        h_cond = cond_ex;
        h_ill  = illegal_ex;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int n;
    int cnt;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    imm_in    = '0;
    npc_in    = '0;
    ir_in     = '0;

    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_outs", alu_out | b_ex | npc_ex | ir_ex, 32'd0);
    check("rst_flags", {30'd0, cond_ex, illegal_ex}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed single-cycle ops.
    alu_case("add_wrap", 6'b000000, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h40, 32'h0000_0001, 1'b0, 32'h40, 1'b0);
    alu_case("slt_neg", 6'b000100, 32'h8000_0000, 32'd1, 32'h0, 32'h44, 32'd1, 1'b0, 32'h44, 1'b0);
    alu_case("slti_neg_imm", 6'b010100, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h48, 32'd0, 1'b0, 32'h48, 1'b0);
    alu_case("sub", 6'b000001, 32'd3, 32'd5, 32'h0, 32'h4C, 32'hFFFF_FFFE, 1'b0, 32'h4C, 1'b0);
    alu_case("and", 6'b000010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h50, 32'h0000_F000, 1'b0, 32'h50, 1'b0);
    alu_case("or", 6'b000011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h54, 32'h0000_FFF0, 1'b0, 32'h54, 1'b0);
    alu_case("lw", 6'b001000, 32'h1000, 32'hDEAD, 32'h10, 32'h58, 32'h1010, 1'b0, 32'h58, 1'b0);
    alu_case("sw", 6'b001001, 32'h2000, 32'h1234, 32'hFFFF_FFFC, 32'h5C, 32'h1FFC, 1'b0, 32'h5C, 1'b0);
    alu_case("addi", 6'b010000, 32'd7, 32'd100, 32'd3, 32'h60, 32'd10, 1'b0, 32'h60, 1'b0);
    alu_case("subi", 6'b010001, 32'd7, 32'd100, 32'd3, 32'h64, 32'd4, 1'b0, 32'h64, 1'b0);
    alu_case("beqz_taken", 6'b110100, 32'd0, 32'd9, 32'h20, 32'h100, 32'h120, 1'b1, 32'h120, 1'b0);
    alu_case("bnez_not", 6'b110101, 32'd0, 32'd9, 32'h20, 32'h100, 32'h120, 1'b0, 32'h100, 1'b0);
    alu_case("bnez_taken", 6'b110101, 32'd5, 32'd9, 32'hFFFF_FFF0, 32'h100, 32'h0F0, 1'b1, 32'h0F0, 1'b0);
    alu_case("hlt", 6'b111111, 32'd5, 32'd6, 32'd7, 32'h68, 32'd0, 1'b0, 32'h68, 1'b0);
    alu_case("undef", 6'b101010, 32'd5, 32'd6, 32'd7, 32'h6C, 32'd0, 1'b0, 32'h6C, 1'b1);

    // Back-to-back: each op after the first must be taken on the first cycle offered.
    issue(6'b000000, 32'd1, 32'd2, 32'd0, 32'h200, w);
    issue(6'b000001, 32'd10, 32'd4, 32'd0, 32'h204, w);
    check("b2b_accept1", w, 32'd1);
    issue(6'b010000, 32'd9, 32'd0, 32'd8, 32'h208, w);
    check("b2b_accept2", w, 32'd1);
    issue(6'b110100, 32'd0, 32'd0, 32'h40, 32'h20C, w);
    check("b2b_accept3", w, 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Output stall: result held with in_ready low, then drained.
    out_ready = 1'b0;
    issue(6'b000011, 32'h00FF_0000, 32'h0000_00FF, 32'd0, 32'h300, w);
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Flush kills a held result and refuses a simultaneous input.
    out_ready = 1'b0;
    issue(6'b000000, 32'd3, 32'd4, 32'd0, 32'h310, w);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    ir_in    = {6'b000000, 26'h0};
    @(negedge clk);
    check("flush_not_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid_low", {31'd0, out_valid}, 32'd0);
    check("flush_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

`ifdef EXE_MULDIV_EN
    // MUL with MEM ready: product lands exactly XLEN+1 cycles after acceptance.
    issue(6'b000101, 32'h0001_0000, 32'h0001_0003, 32'd0, 32'h400, w);
    n = 0;
    for (int i = 1; i <= 60 && n == 0; i++) begin
      @(negedge clk);
      if (out_valid) n = i;
      else check("mul_ready_low", {31'd0, in_ready}, 32'd0);
    end
    check("mul_latency", n, 32'd33);
    check("mul_product", alu_out, 32'h0003_0000);
    check("mul_npc", npc_ex, 32'h400);
    @(posedge clk);
    #1;

    // MUL with MEM stalled: product waits in the output register until out_ready rises.
    out_ready = 1'b0;
    issue(6'b000101, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h410, w);
    n = 0;
    for (int i = 1; i <= 60 && n == 0; i++) begin
      @(negedge clk);
      if (out_valid) n = i;
    end
    check("mul_stall_latency", n, 32'd33);
    check("mul_stall_product", alu_out, 32'hFFFF_FFFD);
    repeat (3) begin
      @(negedge clk);
      check("mul_stall_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Flush during RUN with a simultaneous input: nothing emitted, nothing accepted.
    issue(6'b000101, 32'd7, 32'd9, 32'd0, 32'h420, w);
    repeat (5) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    ir_in    = {6'b000000, 26'h0};
    @(negedge clk);
    check("run_flush_not_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("run_flush_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("run_flush_no_result", cnt, 32'd0);

    // Reset in the middle of a multiply clears everything at once.
    @(posedge clk);
    #1;
    issue(6'b000101, 32'd11, 32'd13, 32'd0, 32'h430, w);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_alu", alu_out, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready_back", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("mid_rst_no_result", cnt, 32'd0);
    @(posedge clk);
    #1;
`else
    // Without the multiplier MUL is a one-cycle illegal op.
    alu_case("mul_illegal", 6'b000101, 32'h0001_0000, 32'h0001_0003, 32'd0, 32'h400,
             32'd0, 1'b0, 32'h400, 1'b1);

    // Reset in the middle of a stalled result clears everything at once.
    out_ready = 1'b0;
    issue(6'b000000, 32'd11, 32'd13, 32'd0, 32'h430, w);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_alu", alu_out, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
`endif

    // A final op after all the disturbances still flows through.
    alu_case("tail_add", 6'b000000, 32'h1234_0000, 32'h0000_5678, 32'd0, 32'h500,
             32'h1234_5678, 1'b0, 32'h500, 1'b0);
    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
